// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer: issue stage in front of the calculator datapath.
// Commands are queued in a small FIFO and issued one at a time. Each command
// is held stable on calc_* for two cycles (ISSUE, CAPTURE) so that the
// calculator's one-cycle registered result can be captured. The result is
// then offered on a valid/ready response channel. Unsupported opcodes
// (0, 5=DIV, 6, 7) are answered locally with rsp_err=1 and are never issued.
//
// Ports:
//   calc_clock, calc_rst        clock, synchronous active-low reset
//   cmd_valid/cmd_ready         command channel (opcode, op1, op2, sel, tag)
//   calc_opcode/op_in1/op_in2/op_in_sel   drive to calculator
//   calc_result, calc_valid_res           registered result from calculator
//   rsp_valid/rsp_ready         response channel (result, tag, err)
//   busy                        FSM not idle or FIFO non-empty
//   fifo_level                  FIFO occupancy
//   stat_done, stat_err         response / error-response counters
//
// Optional feature: define CALC_SEQ_STATS_EN to enable the saturating
// stat_done/stat_err counters; without it both ports are tied to 0.
module calc_cmd_sequencer #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TW    = 4
) (
  input  logic                      calc_clock,
  input  logic                      calc_rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd_opcode,
  input  logic [DW-1:0]             cmd_op1,
  input  logic [DW-1:0]             cmd_op2,
  input  logic                      cmd_sel,
  input  logic [TW-1:0]             cmd_tag,
  output logic [2:0]                calc_opcode,
  output logic [DW-1:0]             calc_op_in1,
  output logic [DW-1:0]             calc_op_in2,
  output logic                      calc_op_in_sel,
  input  logic [2*DW-1:0]           calc_result,
  input  logic                      calc_valid_res,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [2*DW-1:0]           rsp_result,
  output logic [TW-1:0]             rsp_tag,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [15:0]               stat_done,
  output logic [15:0]               stat_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_t;

  typedef struct packed {
    logic [2:0]    opcode;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic          sel;
    logic [TW-1:0] tag;
  } cmd_t;

  cmd_t            mem [DEPTH];
  cmd_t            head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  state_t          state;
  logic [TW-1:0]   tag_q;

  logic            push;
  logic            pop;
  logic            rsp_hs;
  logic            head_ok;
  logic            busy_next;
  logic [LW-1:0]   level_next;

  assign head = mem[rd_ptr];

  // Handshake decode and next occupancy; busy is registered from next-state terms.
  always_comb begin
    push       = cmd_valid && cmd_ready;
    pop        = (state == S_IDLE) && (fifo_level != '0);
    rsp_hs     = rsp_valid && rsp_ready;
    head_ok    = (head.opcode >= 3'd1) && (head.opcode <= 3'd4);
    level_next = fifo_level + LW'(push) - LW'(pop);
    busy_next  = (level_next != '0) || pop ||
                 (state == S_ISSUE) || (state == S_CAPTURE) ||
                 ((state == S_RESP) && !rsp_hs);
  end

  // FIFO storage; contents need no reset, pointers and level carry validity.
  always_ff @(posedge calc_clock) begin
    if (push) begin
      mem[wr_ptr] <= '{opcode: cmd_opcode, op1: cmd_op1, op2: cmd_op2,
                       sel: cmd_sel, tag: cmd_tag};
    end
  end

  // FIFO pointers, sequencing FSM and all registered outputs.
  always_ff @(posedge calc_clock) begin
    if (!calc_rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      cmd_ready      <= 1'b1;
      busy           <= 1'b0;
      state          <= S_IDLE;
      tag_q          <= '0;
      calc_opcode    <= '0;
      calc_op_in1    <= '0;
      calc_op_in2    <= '0;
      calc_op_in_sel <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_result     <= '0;
      rsp_tag        <= '0;
      rsp_err        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= level_next;
      cmd_ready  <= (level_next != LW'(DEPTH));
      busy       <= busy_next;

      case (state)
        S_IDLE: begin
          if (pop) begin
            tag_q <= head.tag;
            if (head_ok) begin
              // calc_* are loaded here so they are valid throughout ISSUE.
              calc_opcode    <= head.opcode;
              calc_op_in1    <= head.op1;
              calc_op_in2    <= head.op2;
              calc_op_in_sel <= head.sel;
              state          <= S_ISSUE;
            end else begin
              rsp_result <= '0;
              rsp_err    <= 1'b1;
              rsp_tag    <= head.tag;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // Calculator result for the held command is valid this cycle.
          rsp_result     <= calc_result;
          rsp_err        <= !calc_valid_res;
          rsp_tag        <= tag_q;
          rsp_valid      <= 1'b1;
          calc_opcode    <= '0;
          calc_op_in1    <= '0;
          calc_op_in2    <= '0;
          calc_op_in_sel <= 1'b0;
          state          <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CALC_SEQ_STATS_EN
  // Saturating response counters, advanced on each response handshake.
  always_ff @(posedge calc_clock) begin
    if (!calc_rst) begin
      stat_done <= '0;
      stat_err  <= '0;
    end else if (rsp_hs) begin
      if (stat_done != 16'hFFFF) stat_done <= stat_done + 16'd1;
      if (rsp_err && (stat_err != 16'hFFFF)) stat_err <= stat_err + 16'd1;
    end
  end
`else
  assign stat_done = '0;
  assign stat_err  = '0;
`endif

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Self-checking bench for calc_cmd_sequencer: directed scenarios followed by
// a randomized run scored against an expected-response queue. The bench also
// stands in for the calculator with a one-cycle registered result path.
module tb_calc_cmd_sequencer;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TW    = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;
  localparam int          NR    = 200;

  logic              clk = 1'b0;
  logic              calc_rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_opcode;
  logic [DW-1:0]     cmd_op1;
  logic [DW-1:0]     cmd_op2;
  logic              cmd_sel;
  logic [TW-1:0]     cmd_tag;
  logic [2:0]        calc_opcode;
  logic [DW-1:0]     calc_op_in1;
  logic [DW-1:0]     calc_op_in2;
  logic              calc_op_in_sel;
  logic [2*DW-1:0]   calc_result;
  logic              calc_valid_res;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2*DW-1:0]   rsp_result;
  logic [TW-1:0]     rsp_tag;
  logic              rsp_err;
  logic              busy;
  logic [LW-1:0]     fifo_level;
  logic [15:0]       stat_done;
  logic [15:0]       stat_err;

  always #5 clk = ~clk;

  calc_cmd_sequencer #(.DW(DW), .DEPTH(DEPTH), .TW(TW)) dut (
    .calc_clock     (clk),
    .calc_rst       (calc_rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_opcode     (cmd_opcode),
    .cmd_op1        (cmd_op1),
    .cmd_op2        (cmd_op2),
    .cmd_sel        (cmd_sel),
    .cmd_tag        (cmd_tag),
    .calc_opcode    (calc_opcode),
    .calc_op_in1    (calc_op_in1),
    .calc_op_in2    (calc_op_in2),
    .calc_op_in_sel (calc_op_in_sel),
    .calc_result    (calc_result),
    .calc_valid_res (calc_valid_res),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_result     (rsp_result),
    .rsp_tag        (rsp_tag),
    .rsp_err        (rsp_err),
    .busy           (busy),
    .fifo_level     (fifo_level),
    .stat_done      (stat_done),
    .stat_err       (stat_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] acc_op;

  typedef struct {
    logic [63:0]   res;
    logic          err;
    logic [TW-1:0] tag;
  } exp_t;
  exp_t q[$];

  function automatic logic [63:0] isqrt(input logic [31:0] x);
    logic [63:0] r = 64'd0;
    logic [63:0] t;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= {32'd0, x}) r = t;
    end
    return r;
  endfunction

  // Calculator arithmetic: returns {valid, result}.
  function automatic logic [64:0] calc_fn(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic sel);
    logic [32:0] s;
    case (op)
      3'd1: begin
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? {1'b0, 64'd0} : {1'b1, 31'd0, s};
      end
      3'd2: return {1'b1, {32'd0, a} * {32'd0, b}};
      3'd3: return (b >= a) ? {1'b1, 32'd0, b - a} : {1'b0, 64'd0};
      3'd4: return {1'b1, isqrt(sel ? a : b)};
      default: return {1'b0, 64'd0};
    endcase
  endfunction

  // Expected response for a command: {err, result}.
  function automatic logic [64:0] ref_rsp(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic sel);
    logic [64:0] c;
    if (op >= 3'd1 && op <= 3'd4) begin
      c = calc_fn(op, a, b, sel);
      return {~c[64], c[63:0]};
    end
    return {1'b1, 64'd0};
  endfunction

  // Calculator stand-in: one-cycle registered result.
  always @(posedge clk) begin
    {calc_valid_res, calc_result} <= calc_fn(calc_opcode, calc_op_in1, calc_op_in2, calc_op_in_sel);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic sel, input logic [TW-1:0] tag, output int t);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    cmd_opcode = op;
    cmd_op1    = a;
    cmd_op2    = b;
    cmd_sel    = sel;
    cmd_tag    = tag;
    cmd_valid  = 1'b1;
    t = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int t);
    int n = 0;
    acc_op = acc_op | calc_opcode;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      acc_op = acc_op | calc_opcode;
      n++;
    end
    t = (rsp_valid === 1'b1) ? cyc : -1000;
  endtask

  // One command in isolation with rsp_ready held high.
  task automatic single(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic sel, input logic [TW-1:0] tag,
                        input logic [63:0] exp_res, input logic exp_err, input int exp_lat);
    int t0, t1;
    acc_op = 3'd0;
    push(op, a, b, sel, tag, t0);
    wait_rsp(t1);
    check({name, "_latency"}, 64'(t1 - t0), 64'(exp_lat));
    check({name, "_result"}, rsp_result, exp_res);
    check({name, "_err"}, 64'(rsp_err), 64'(exp_err));
    check({name, "_tag"}, 64'(rsp_tag), 64'(tag));
    if (exp_err && exp_lat == 2) check({name, "_calc_idle"}, 64'(acc_op), 64'd0);
    @(negedge clk);
    check({name, "_valid_drop"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int t0, t1, t2, accepted, sent, got, hs, hs_err;
    bit acc_last;
    logic [64:0] e;
    exp_t ex;

    calc_rst   = 1'b0;
    cmd_valid  = 1'b0;
    cmd_opcode = 3'd0;
    cmd_op1    = '0;
    cmd_op2    = '0;
    cmd_sel    = 1'b0;
    cmd_tag    = '0;
    rsp_ready  = 1'b1;
    acc_op     = 3'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_fifo_level", 64'(fifo_level), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_calc_opcode", 64'(calc_opcode), 64'd0);
    check("rst_rsp_result", rsp_result, 64'd0);
    check("rst_stat_done", 64'(stat_done), 64'd0);
    calc_rst = 1'b1;
    @(negedge clk);

    // Supported opcodes, overflow and SQRT source selection
    single("sum", 3'd1, 32'd3, 32'd5, 1'b0, 4'd1, 64'h8, 1'b0, 4);
    single("sum_ovf", 3'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd4, 64'h0, 1'b1, 4);
    single("sqrt_op1", 3'd4, 32'd16, 32'd81, 1'b1, 4'd5, 64'h4, 1'b0, 4);
    single("sqrt_op2", 3'd4, 32'd16, 32'd81, 1'b0, 4'd6, 64'h9, 1'b0, 4);

    // Locally rejected opcodes
    single("div", 3'd5, 32'd10, 32'd2, 1'b0, 4'd7, 64'h0, 1'b1, 2);
    single("op0", 3'd0, 32'd1, 32'd2, 1'b0, 4'd8, 64'h0, 1'b1, 2);
    single("op7", 3'd7, 32'd1, 32'd2, 1'b0, 4'd9, 64'h0, 1'b1, 2);

    // Back-to-back SUB then MULT, responses in order 4 cycles apart
    push(3'd3, 32'd3, 32'd10, 1'b0, 4'd2, t0);
    push(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 4'd3, t2);
    wait_rsp(t1);
    check("b2b_first_latency", 64'(t1 - t0), 64'd4);
    check("b2b_first_result", rsp_result, 64'h7);
    check("b2b_first_tag", 64'(rsp_tag), 64'd2);
    @(negedge clk);
    wait_rsp(t2);
    check("b2b_spacing", 64'(t2 - t1), 64'd4);
    check("b2b_second_result", rsp_result, 64'h1_FFFF_FFFE);
    check("b2b_second_err", 64'(rsp_err), 64'd0);
    check("b2b_second_tag", 64'(rsp_tag), 64'd3);
    @(negedge clk);

    // Backpressure: FIFO fills behind a stalled response
    rsp_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      cmd_opcode = 3'd1;
      cmd_op1    = 32'(i + 1);
      cmd_op2    = 32'(i);
      cmd_sel    = 1'b0;
      cmd_tag    = TW'(i);
      cmd_valid  = 1'b1;
      for (int k = 0; k < 4 && cmd_ready !== 1'b1; k++) @(negedge clk);
      if (cmd_ready === 1'b1) accepted++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("bp_accepted", 64'(accepted), 64'(DEPTH + 1));
    check("bp_fifo_level", 64'(fifo_level), 64'(DEPTH));
    check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    check("bp_rsp_result", rsp_result, 64'd1);
    check("bp_busy", 64'(busy), 64'd1);

    // Release the response; reset lands while the next command is in CAPTURE
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("issue_opcode", 64'(calc_opcode), 64'd1);
    check("issue_op1", 64'(calc_op_in1), 64'd2);
    @(negedge clk);
    calc_rst = 1'b0;
    @(negedge clk);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_fifo_level", 64'(fifo_level), 64'd0);
    check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("midrst_calc_opcode", 64'(calc_opcode), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    calc_rst = 1'b1;
    @(negedge clk);

    // Randomized traffic with random response backpressure
    sent = 0; got = 0; hs = 0; hs_err = 0; acc_last = 1'b0;
    for (int c = 0; c < 20000 && got < NR; c++) begin
      @(negedge clk);
      if (acc_last) cmd_valid = 1'b0;
      if (!cmd_valid && sent < NR && $urandom_range(0, 3) != 0) begin
        cmd_opcode = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7));
        cmd_op1    = $urandom;
        cmd_op2    = $urandom;
        if ($urandom_range(0, 1) == 1) cmd_op1 = cmd_op1 & 32'h0000_FFFF;
        if ($urandom_range(0, 1) == 1) cmd_op2 = cmd_op2 & 32'h0000_FFFF;
        cmd_sel    = 1'($urandom_range(0, 1));
        cmd_tag    = TW'(sent);
        cmd_valid  = 1'b1;
      end
      acc_last = cmd_valid && (cmd_ready === 1'b1);
      if (acc_last) begin
        e = ref_rsp(cmd_opcode, cmd_op1, cmd_op2, cmd_sel);
        q.push_back('{res: e[63:0], err: e[64], tag: cmd_tag});
        sent++;
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      if (rsp_valid === 1'b1 && rsp_ready) begin
        if (q.size() == 0) begin
          check("rand_spurious_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          ex = q.pop_front();
          check("rand_result", rsp_result, ex.res);
          check("rand_err", 64'(rsp_err), 64'(ex.err));
          check("rand_tag", 64'(rsp_tag), 64'(ex.tag));
          if (ex.err) hs_err++;
        end
        got++;
        hs++;
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rand_responses", 64'(got), 64'(NR));
    check("rand_drained_level", 64'(fifo_level), 64'd0);
    check("rand_drained_busy", 64'(busy), 64'd0);
`ifdef CALC_SEQ_STATS_EN
    check("stat_done", 64'(stat_done), 64'(hs));
    check("stat_err", 64'(stat_err), 64'(hs_err));
`else
    check("stat_done_tied", 64'(stat_done), 64'd0);
    check("stat_err_tied", 64'(stat_err), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/calc_cmd_sequencer.md
Name: calc_cmd_sequencer

Overview:
Upstream issue stage for the calculator datapath. Buffers operation commands in a small FIFO and drives them one at a time onto the calculator's opcode/operand ports. Holds each command stable across the calculator's one-cycle registered result path, then captures result and valid flag into a valid/ready response channel. Rejects unsupported opcodes locally, without issuing them.

Parameters:
DW, 32, operand width; result width is 2*DW
DEPTH, 4, command FIFO entries; power of 2, at least 2
TW, 4, command tag width; the tag is returned with the response

Ports:
calc_clock  in  1  single clock; all logic is on the rising edge
calc_rst  in  1  reset, synchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; equals !full
cmd_opcode  in  3  1=SUM 2=MULT 3=SUB 4=SQRT 5=DIV
cmd_op1  in  DW  operand 1
cmd_op2  in  DW  operand 2
cmd_sel  in  1  SQRT source select: 1=op1, 0=op2
cmd_tag  in  TW  command tag
calc_opcode  out  3  to calculator opcode
calc_op_in1  out  DW  to calculator op_in1
calc_op_in2  out  DW  to calculator op_in2
calc_op_in_sel  out  1  to calculator op_in_sel
calc_result  in  2*DW  from calculator result
calc_valid_res  in  1  from calculator valid_res
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_result  out  2*DW  captured result
rsp_tag  out  TW  tag of the completed command
rsp_err  out  1  1 = overflow or unsupported opcode
busy  out  1  state is not IDLE, or the FIFO is non-empty
fifo_level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (calc_rst=0 at a clock edge): FIFO emptied, state=IDLE, in-flight command discarded. All outputs are 0 except cmd_ready=1. Reset overrides every other event.
- FIFO:
  - Push on cmd_valid&&cmd_ready.
  - When full, cmd_ready=0. No bypass path.
  - Push and pop in the same cycle are both allowed; fifo_level is unchanged.
  - Pointers wrap modulo DEPTH.
- Idle drive: calc_* outputs are 0 whenever state is not ISSUE or CAPTURE.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE: if the FIFO is non-empty, pop the head into the command register.
    - Opcode in 1..4: go to ISSUE.
    - Opcode 0, 5 (DIV, no datapath support) or 6..7: load rsp_result=0, rsp_err=1, rsp_tag; go to RESP.
  - ISSUE: drive calc_* from the command register for one cycle; go to CAPTURE.
  - CAPTURE: keep driving the identical values. At the cycle end, register rsp_result=calc_result, rsp_err=!calc_valid_res, rsp_tag; go to RESP.
  - RESP: rsp_valid=1. Outputs hold stable until rsp_valid&&rsp_ready, then return to IDLE. rsp_valid drops in the next cycle.
- Latency, with the command accepted at the edge ending cycle T:
  - Supported opcode: rsp_valid first high in cycle T+4.
  - Rejected opcode: rsp_valid first high in cycle T+2.
  - Back-to-back supported commands with rsp_ready held at 1: one response every 4 cycles.
- Overflow: when calc_valid_res=0 in CAPTURE, calc_result is already 0; rsp_result=0 and rsp_err=1.
- Response ordering: strictly FIFO order; tags are not reordered.
- Backpressure: while in RESP, the FIFO still accepts pushes until full.

Optional Feature:
CALC_SEQ_STATS_EN: adds output ports stat_done[15:0] and stat_err[15:0].
- Both counters reset to 0.
- stat_done increments on every response handshake.
- stat_err increments on handshakes with rsp_err=1.
- Both saturate at 16'hFFFF.
- Without the macro, both ports exist and are tied to 0, with no counter logic.

Test Plan:
- SUM op1=3, op2=5, tag=1 -> rsp_result=64'h8, rsp_err=0, rsp_tag=1; rsp_valid in cycle T+4.
- SUB op1=3, op2=10, then MULT op1=32'hFFFFFFFF, op2=2, pushed back-to-back -> 64'h7, then 64'h1_FFFF_FFFE, in order, 4 cycles apart.
- SUM op1=32'hFFFFFFFF, op2=1 -> rsp_result=0, rsp_err=1.
- SQRT sel=1, op1=16, op2=81 -> rsp_result=4. Same command with sel=0 -> rsp_result=9.
- DIV, opcode 0 and opcode 7 -> rsp_err=1, rsp_result=0, rsp_valid in cycle T+2; calc_opcode stays 0 throughout.
- With rsp_ready=0, push DEPTH+2 commands -> cmd_ready=0 at fifo_level=DEPTH. Assert calc_rst=0 mid-CAPTURE -> next cycle rsp_valid=0, fifo_level=0, cmd_ready=1, calc_opcode=0.
